bus_slave_regs: RTL and testbench

BUS_SLAVE_REGS -- requirements
Module: bus_slave_regs

---
 rtl/bus_slave_pkg.sv | 52 +++++
 rtl/bus_slave_fsm.sv | 106 ++++++++++
 rtl/bus_slave_regs.sv | 138 +++++++++++++
 tb/tb_bus_slave_regs.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_slave_pkg.sv
// bus_slave_pkg
// Shared definitions for the bus slave register block: bus widths, the
// READ/WRITE encoding of rw, the register index map, the FSM state encoding
// and the legal range of the WAIT_STATES parameter.
package bus_slave_pkg;

    // Bus widths (word-addressed 32-bit bus)
    localparam int WORD_ADDR_W = 30;
    localparam int WORD_DATA_W = 32;

    // rw encoding
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // WAIT_STATES range and the width of the wait counter that covers it
    localparam int WAIT_STATES_MAX = 15;
    localparam int WAIT_CNT_W      = 4;

    // Event / interrupt width
    localparam int EVT_W = 4;

    // Number of general-purpose scratch registers
    localparam int GP_NUM = 5;

    // Register index map (decoded from addr[2:0])
    localparam logic [2:0] REG_CTRL = 3'd0;
    localparam logic [2:0] REG_GP1  = 3'd1;
    localparam logic [2:0] REG_GP2  = 3'd2;
    localparam logic [2:0] REG_GP3  = 3'd3;
    localparam logic [2:0] REG_GP4  = 3'd4;
    localparam logic [2:0] REG_GP5  = 3'd5;
    localparam logic [2:0] REG_EVT  = 3'd6;
    localparam logic [2:0] REG_CNT  = 3'd7;

    // Bus FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } bus_state_t;

    // Clamp a requested wait-state count into the supported range.
    function automatic int clamp_wait(input int ws);
        if (ws < 0) begin
            return 0;
        end else if (ws > WAIT_STATES_MAX) begin
            return WAIT_STATES_MAX;
        end
        return ws;
    endfunction

endpackage

// File: rtl/bus_slave_fsm.sv
// bus_slave_fsm
// Bus handshake engine: samples the chip-select/strobe inputs, latches the
// register index and direction of an accepted transaction, counts the wait
// states and generates the one-cycle active-low ready pulse.
//
// Ports:
//   clk      in   clock, all state changes on the rising edge
//   rst      in   synchronous reset, active-low
//   cs_      in   chip select, active-low
//   as_      in   address strobe, active-low single-cycle pulse
//   rw       in   direction (RW_READ / RW_WRITE)
//   addr_lo  in   addr[2:0], register index
//   ready    out  high during the READY cycle (the cycle rdy_ is low)
//   rd_op    out  latched direction of the current transaction is read
//   idx      out  latched register index of the current transaction
//   rdy_     out  registered ready, active-low
module bus_slave_fsm
    import bus_slave_pkg::*;
#(
    parameter int WAIT_STATES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs_,
    input  logic       as_,
    input  logic       rw,
    input  logic [2:0] addr_lo,
    output logic       ready,
    output logic       rd_op,
    output logic [2:0] idx,
    output logic       rdy_
);

    localparam int WS = clamp_wait(WAIT_STATES);
    // The counter is loaded with WS-1 so that WS wait cycles elapse before READY.
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (WS > 0) ? WAIT_CNT_W'(WS - 1) : '0;

    // Input sampling stage: the strobe and its qualifiers are captured at the
    // sampling edge and acted upon by the state machine one edge later.
    logic                  strobe_reg;
    logic                  rw_s_reg;
    logic [2:0]            addr_s_reg;

    bus_state_t            state_reg;
    logic [WAIT_CNT_W-1:0] wait_reg;
    logic [2:0]            idx_reg;
    logic                  rd_op_reg;
    logic                  rdy_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            strobe_reg <= 1'b0;
            rw_s_reg   <= 1'b0;
            addr_s_reg <= '0;
            state_reg  <= ST_IDLE;
            wait_reg   <= '0;
            idx_reg    <= '0;
            rd_op_reg  <= 1'b0;
            rdy_reg    <= 1'b1;
        end else begin
            strobe_reg <= ~cs_ & ~as_;
            rw_s_reg   <= rw;
            addr_s_reg <= addr_lo;
            // rdy_ is low only for the single cycle spent in READY
            rdy_reg    <= 1'b1;

            case (state_reg)
                ST_IDLE: begin
                    if (strobe_reg) begin
                        idx_reg   <= addr_s_reg;
                        rd_op_reg <= (rw_s_reg == RW_READ);
                        if (WS > 0) begin
                            state_reg <= ST_WAIT;
                            wait_reg  <= WAIT_LOAD;
                        end else begin
                            state_reg <= ST_READY;
                            rdy_reg   <= 1'b0;
                        end
                    end
                end
                ST_WAIT: begin
                    // Strobes arriving here are simply not looked at.
                    if (wait_reg == '0) begin
                        state_reg <= ST_READY;
                        rdy_reg   <= 1'b0;
                    end else begin
                        wait_reg <= wait_reg - 1'b1;
                    end
                end
                ST_READY: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready = (state_reg == ST_READY);
    assign rd_op = rd_op_reg;
    assign idx   = idx_reg;
    assign rdy_  = rdy_reg;

endmodule

// File: rtl/bus_slave_regs.sv
// bus_slave_regs
// Memory-mapped register block on an asynchronous-style handshake bus.
// Map: 0 CTRL (bits 3:0 irq enables), 1-5 GP1-GP5 scratch, 6 EVT (sticky
// event flags, write-1-to-clear), 7 CNT (completed transaction counter,
// read-only). The bus handshake lives in bus_slave_fsm; this module holds
// the register file, read mux and interrupt logic.
//
// Ports:
//   clk       in   clock
//   rst       in   synchronous reset, active-low
//   cs_       in   chip select, active-low
//   as_       in   address strobe, active-low
//   rw        in   direction (RW_READ / RW_WRITE)
//   addr      in   word address, only [2:0] decoded
//   wr_data   in   write data, taken in the READY cycle
//   rd_data   out  read data, zero except in the rdy_ cycle of a read
//   rdy_      out  ready, active-low, one cycle per transaction
//   event_in  in   event pulses, one per EVT bit
//   irq       out  registered interrupt, OR over (EVT & CTRL[3:0])
module bus_slave_regs
    import bus_slave_pkg::*;
#(
    parameter int WAIT_STATES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cs_,
    input  logic                   as_,
    input  logic                   rw,
    input  logic [WORD_ADDR_W-1:0] addr,
    input  logic [WORD_DATA_W-1:0] wr_data,
    output logic [WORD_DATA_W-1:0] rd_data,
    output logic                   rdy_,
    input  logic [EVT_W-1:0]       event_in,
    output logic                   irq
);

    logic       ready;
    logic       rd_op;
    logic [2:0] idx;

    bus_slave_fsm #(
        .WAIT_STATES (WAIT_STATES)
    ) u_fsm (
        .clk     (clk),
        .rst     (rst),
        .cs_     (cs_),
        .as_     (as_),
        .rw      (rw),
        .addr_lo (addr[2:0]),
        .ready   (ready),
        .rd_op   (rd_op),
        .idx     (idx),
        .rdy_    (rdy_)
    );

    // Upper address bits belong to the external decoder.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[WORD_ADDR_W-1:3];

    logic [WORD_DATA_W-1:0] ctrl_reg;
    logic [WORD_DATA_W-1:0] gp_reg [GP_NUM];
    logic [EVT_W-1:0]       evt_reg;
    logic [WORD_DATA_W-1:0] cnt_reg;
    logic                   irq_reg;

    logic                   wr_en;
    logic                   ctrl_we;
    logic [GP_NUM-1:0]      gp_we;
    logic [EVT_W-1:0]       evt_clr;
    logic [EVT_W-1:0]       evt_next;
    logic [WORD_DATA_W-1:0] cnt_next;
    logic [WORD_DATA_W-1:0] rd_mux;

    // The write lands on the edge that closes the READY cycle.
    assign wr_en   = ready & ~rd_op;
    assign ctrl_we = wr_en && (idx == REG_CTRL);

    generate
        for (genvar gi = 0; gi < GP_NUM; gi++) begin : g_gp_we
            assign gp_we[gi] = wr_en && (idx == 3'(int'(REG_GP1) + gi));
        end
    endgenerate

    // New events override a simultaneous write-1-to-clear of the same bit.
    assign evt_clr  = (wr_en && (idx == REG_EVT)) ? wr_data[EVT_W-1:0] : '0;
    assign evt_next = (evt_reg & ~evt_clr) | event_in;

    // Every completed transaction counts, including ignored writes to CNT;
    // the counter wraps silently.
    assign cnt_next = cnt_reg + WORD_DATA_W'(ready);

    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrl_reg <= '0;
            for (int i = 0; i < GP_NUM; i++) begin
                gp_reg[i] <= '0;
            end
            evt_reg  <= '0;
            cnt_reg  <= '0;
            irq_reg  <= 1'b0;
        end else begin
            if (ctrl_we) begin
                ctrl_reg <= wr_data;
            end
            for (int i = 0; i < GP_NUM; i++) begin
                if (gp_we[i]) begin
                    gp_reg[i] <= wr_data;
                end
            end
            evt_reg <= evt_next;
            cnt_reg <= cnt_next;
            irq_reg <= |(evt_reg & ctrl_reg[EVT_W-1:0]);
        end
    end

    // Read mux sees pre-edge register values, so EVT/CNT reads in READY
    // return the value before this cycle's update.
    always_comb begin
        rd_mux = '0;
        case (idx)
            REG_CTRL: rd_mux = ctrl_reg;
            REG_GP1:  rd_mux = gp_reg[0];
            REG_GP2:  rd_mux = gp_reg[1];
            REG_GP3:  rd_mux = gp_reg[2];
            REG_GP4:  rd_mux = gp_reg[3];
            REG_GP5:  rd_mux = gp_reg[4];
            REG_EVT:  rd_mux = {{(WORD_DATA_W-EVT_W){1'b0}}, evt_reg};
            REG_CNT:  rd_mux = cnt_reg;
            default:  rd_mux = '0;
        endcase
    end

    // Zero outside a read's READY cycle so several slaves can be OR-ed.
    assign rd_data = (ready && rd_op) ? rd_mux : '0;
    assign irq     = irq_reg;

endmodule

// File: tb/tb_bus_slave_regs.sv
// tb_bus_slave_regs
// Directed bench for bus_slave_regs with three instances: WAIT_STATES=1
// (register map, events, irq, counter), WAIT_STATES=0 (minimum latency and
// idle rd_data) and WAIT_STATES=3 (strobe ignoring, cs_ qualification and
// reset during a wait). Expected read data is queued at strobe time and
// compared when rdy_ is seen.
module tb_bus_slave_regs;
    import bus_slave_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst_b      [3];
    logic                   cs_b       [3];
    logic                   as_b       [3];
    logic                   rw_b       [3];
    logic [WORD_ADDR_W-1:0] addr_b     [3];
    logic [WORD_DATA_W-1:0] wd_b       [3];
    logic [WORD_DATA_W-1:0] rd_data_b  [3];
    logic                   rdy_b      [3];
    logic [EVT_W-1:0]       event_in_b [3];
    logic                   irq_b      [3];

    int checks = 0;
    int passes = 0;
    logic [31:0] sb [$];
    logic [31:0] cnt_m;
    logic bg_en = 1'b0;

    bus_slave_regs #(.WAIT_STATES(1)) u_ws1 (
        .clk(clk), .rst(rst_b[0]), .cs_(cs_b[0]), .as_(as_b[0]), .rw(rw_b[0]),
        .addr(addr_b[0]), .wr_data(wd_b[0]), .rd_data(rd_data_b[0]),
        .rdy_(rdy_b[0]), .event_in(event_in_b[0]), .irq(irq_b[0])
    );
    bus_slave_regs #(.WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst_b[1]), .cs_(cs_b[1]), .as_(as_b[1]), .rw(rw_b[1]),
        .addr(addr_b[1]), .wr_data(wd_b[1]), .rd_data(rd_data_b[1]),
        .rdy_(rdy_b[1]), .event_in(event_in_b[1]), .irq(irq_b[1])
    );
    bus_slave_regs #(.WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst_b[2]), .cs_(cs_b[2]), .as_(as_b[2]), .rw(rw_b[2]),
        .addr(addr_b[2]), .wr_data(wd_b[2]), .rd_data(rd_data_b[2]),
        .rdy_(rdy_b[2]), .event_in(event_in_b[2]), .irq(irq_b[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One bus transaction: strobe for one cycle, expect rdy_ at ws+2
    // negedges after the strobe edge, compare read data, then expect the
    // pulse to end after one cycle.
    task automatic xact(input int k, input logic rwv, input logic [2:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input int ws, input string tag);
        int n;
        logic got;
        logic [31:0] e;
        @(negedge clk);
        cs_b[k] = 1'b0; as_b[k] = 1'b0; rw_b[k] = rwv;
        addr_b[k] = {27'b0, a}; wd_b[k] = wd;
        sb.push_back(exp_rd);
        @(posedge clk);
        #1;
        cs_b[k] = 1'b1; as_b[k] = 1'b1;
        n = 0; got = 1'b0;
        while (n < 40 && !got) begin
            @(negedge clk);
            n++;
            if (rdy_b[k] == 1'b0) got = 1'b1;
        end
        check({tag, "_lat"}, 32'(n), 32'(ws + 2));
        e = (sb.size() > 0) ? sb.pop_front() : 32'hX;
        if (got) check({tag, "_rd"}, rd_data_b[k], e);
        @(negedge clk);
        check({tag, "_rdy_end"}, {31'b0, rdy_b[k]}, 32'd1);
        check({tag, "_rd_end"}, rd_data_b[k], 32'd0);
        rw_b[k] = RW_READ;
        $display("xact inst=%0d %s addr=%0d wd=%h rd=%h lat=%0d", k,
                 (rwv == RW_READ) ? "RD" : "WR", a, wd, e, n);
    endtask

    task automatic count_rdy(input int k, input int start, input int ncyc,
                             output int pulses, output int first, output logic [31:0] dat);
        pulses = 0; first = 0; dat = '0;
        for (int i = start; i < start + ncyc; i++) begin
            @(negedge clk);
            if (rdy_b[k] == 1'b0) begin
                pulses++;
                if (first == 0) begin
                    first = i;
                    dat = rd_data_b[k];
                end
            end
        end
    endtask

    // rd_data of the zero-wait instance must stay zero whenever rdy_ is high.
    always @(negedge clk) begin
        if (bg_en && rdy_b[1]) check("ws0_rd_idle", rd_data_b[1], 32'd0);
    end

    initial begin
        int pulses;
        int first;
        logic [31:0] dat;

        for (int k = 0; k < 3; k++) begin
            rst_b[k] = 1'b0; cs_b[k] = 1'b1; as_b[k] = 1'b1; rw_b[k] = RW_READ;
            addr_b[k] = '0; wd_b[k] = '0; event_in_b[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) rst_b[k] = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_rdy_%0d", k), {31'b0, rdy_b[k]}, 32'd1);
            check($sformatf("rst_rd_%0d", k), rd_data_b[k], 32'd0);
            check($sformatf("rst_irq_%0d", k), {31'b0, irq_b[k]}, 32'd0);
        end
        bg_en = 1'b1;

        // ---- WAIT_STATES=1 instance ----
        cnt_m = 0;
        xact(0, RW_WRITE, REG_GP3, 32'hDEAD_BEEF, 32'd0, 1, "wr_gp3"); cnt_m++;
        xact(0, RW_READ,  REG_GP3, 32'd0, 32'hDEAD_BEEF, 1, "rd_gp3"); cnt_m++;
        xact(0, RW_READ,  REG_CNT, 32'd0, cnt_m, 1, "rd_cnt2"); cnt_m++;
        xact(0, RW_WRITE, REG_CTRL, 32'h0000_0005, 32'd0, 1, "wr_ctrl"); cnt_m++;
        xact(0, RW_READ,  REG_CTRL, 32'd0, 32'h0000_0005, 1, "rd_ctrl"); cnt_m++;

        // Event pulse: EVT sets at the next edge, irq one edge later.
        @(negedge clk);
        event_in_b[0] = 4'b0100;
        @(negedge clk);
        event_in_b[0] = 4'b0000;
        check("irq_early", {31'b0, irq_b[0]}, 32'd0);
        @(negedge clk);
        check("irq_set", {31'b0, irq_b[0]}, 32'd1);
        $display("event pulse inst=0 evt_in=0100 irq=%0b", irq_b[0]);
        xact(0, RW_READ, REG_EVT, 32'd0, 32'h0000_0004, 1, "rd_evt"); cnt_m++;

        // Clear collides with a fresh event on the same bit: bit stays set.
        event_in_b[0] = 4'b0100;
        xact(0, RW_WRITE, REG_EVT, 32'h0000_0004, 32'd0, 1, "clr_evt_hit"); cnt_m++;
        event_in_b[0] = 4'b0000;
        xact(0, RW_READ, REG_EVT, 32'd0, 32'h0000_0004, 1, "rd_evt_kept"); cnt_m++;
        xact(0, RW_WRITE, REG_EVT, 32'h0000_0004, 32'd0, 1, "clr_evt"); cnt_m++;
        xact(0, RW_READ, REG_EVT, 32'd0, 32'd0, 1, "rd_evt_clr"); cnt_m++;
        check("irq_clr", {31'b0, irq_b[0]}, 32'd0);

        // Writes to CNT are acknowledged but ignored.
        xact(0, RW_WRITE, REG_CNT, 32'h0000_1234, 32'd0, 1, "wr_cnt"); cnt_m++;
        xact(0, RW_READ,  REG_CNT, 32'd0, cnt_m, 1, "rd_cnt"); cnt_m++;

        // Counter wrap from all ones.
        @(negedge clk);
        force u_ws1.cnt_reg = 32'hFFFF_FFFF;
        @(negedge clk);
        release u_ws1.cnt_reg;
        cnt_m = 32'hFFFF_FFFF;
        xact(0, RW_WRITE, REG_GP1, 32'h0000_00A5, 32'd0, 1, "wr_gp1_wrap"); cnt_m++;
        xact(0, RW_READ,  REG_CNT, 32'd0, cnt_m, 1, "rd_cnt_wrap"); cnt_m++;
        xact(0, RW_READ,  REG_GP1, 32'd0, 32'h0000_00A5, 1, "rd_gp1"); cnt_m++;

        // ---- WAIT_STATES=0 instance ----
        xact(1, RW_READ, REG_CTRL, 32'd0, 32'd0, 0, "ws0_rd_ctrl");
        xact(1, RW_WRITE, REG_GP5, 32'h1357_9BDF, 32'd0, 0, "ws0_wr_gp5");
        xact(1, RW_READ, REG_GP5, 32'd0, 32'h1357_9BDF, 0, "ws0_rd_gp5");

        // ---- WAIT_STATES=3 instance ----
        // Two strobes one cycle apart: only the first is served.
        @(negedge clk);
        cs_b[2] = 1'b0; as_b[2] = 1'b0; rw_b[2] = RW_READ; addr_b[2] = 30'(REG_CNT);
        sb.push_back(32'd0);
        @(posedge clk);
        #1;
        as_b[2] = 1'b1;
        @(negedge clk);
        as_b[2] = 1'b0; addr_b[2] = 30'(REG_GP2);
        @(posedge clk);
        #1;
        as_b[2] = 1'b1; cs_b[2] = 1'b1;
        count_rdy(2, 2, 20, pulses, first, dat);
        check("dbl_pulses", 32'(pulses), 32'd1);
        check("dbl_lat", 32'(first), 32'd5);
        check("dbl_rd", dat, sb.pop_front());
        $display("double strobe inst=2 pulses=%0d first=%0d rd=%h", pulses, first, dat);

        // Strobe without chip select: no response.
        @(negedge clk);
        cs_b[2] = 1'b1; as_b[2] = 1'b0;
        @(posedge clk);
        #1;
        as_b[2] = 1'b1;
        count_rdy(2, 1, 20, pulses, first, dat);
        check("nocs_pulses", 32'(pulses), 32'd0);
        $display("strobe without cs inst=2 pulses=%0d", pulses);

        // Reset while waiting: transaction dropped.
        @(negedge clk);
        cs_b[2] = 1'b0; as_b[2] = 1'b0; rw_b[2] = RW_WRITE;
        addr_b[2] = 30'(REG_GP2); wd_b[2] = 32'hAAAA_5555;
        @(posedge clk);
        #1;
        as_b[2] = 1'b1; cs_b[2] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_b[2] = 1'b0;
        @(posedge clk);
        #1;
        rst_b[2] = 1'b1; rw_b[2] = RW_READ;
        count_rdy(2, 1, 20, pulses, first, dat);
        check("rstwait_pulses", 32'(pulses), 32'd0);
        $display("reset in wait inst=2 pulses=%0d", pulses);
        xact(2, RW_READ, REG_CNT, 32'd0, 32'd0, 3, "rstwait_cnt");
        xact(2, RW_READ, REG_GP2, 32'd0, 32'd0, 3, "rstwait_gp2");

        check("sb_empty", 32'(sb.size()), 32'd0);
        bg_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
